// File: rtl/studio2_pkg.sv
// Shared types and scan-code tables for the Studio II keypad front end.
package studio2_pkg;

    typedef logic [3:0] key_num_t;

    typedef enum logic {HOLD_IDLE, HOLD_ACTIVE} hold_state_t;

    localparam int unsigned NUM_KEYS = 10;

    // Main-row digits 0..9 for keypad 1, numpad digits 0..9 for keypad 2
    localparam logic [7:0] KP1_CODES [NUM_KEYS] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    localparam logic [7:0] KP2_CODES [NUM_KEYS] = '{
        8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
    };

endpackage

// File: rtl/studio2_key_hold.sv
// Per-pad key vector with release hold-off; all pending releases expire together.
module studio2_key_hold
    import studio2_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                resetq,
    input  logic                key_make,
    input  logic                key_break,
    input  key_num_t            key,
    output logic [NUM_KEYS-1:0] keys
);

    localparam int unsigned CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

    hold_state_t          state, state_n;
    logic [NUM_KEYS-1:0]  pending, pending_n;
    logic [NUM_KEYS-1:0]  keys_n;
    logic [CW-1:0]        cnt, cnt_n;

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            state   <= HOLD_IDLE;
            pending <= '0;
            keys    <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            keys    <= keys_n;
            cnt     <= cnt_n;
        end
    end

    // Expiry is applied first so a same-cycle make of the same key restores it
    always_comb begin
        state_n   = state;
        pending_n = pending;
        keys_n    = keys;
        cnt_n     = cnt;
        if (state == HOLD_ACTIVE) begin
            if (cnt == '0) begin
                keys_n    = keys & ~pending;
                pending_n = '0;
                state_n   = HOLD_IDLE;
            end else begin
                cnt_n = cnt - CW'(1);
            end
        end
        if (key_make) begin
            keys_n[key]    = 1'b1;
            pending_n[key] = 1'b0;
        end else if (key_break && keys[key]) begin
            if (HOLD_CYCLES == 0) begin
                keys_n[key] = 1'b0;
            end else begin
                keys_n[key]    = 1'b1;
                pending_n[key] = 1'b1;
                cnt_n          = CNT_LOAD;
                state_n        = HOLD_ACTIVE;
            end
        end
    end

endmodule

// File: rtl/studio2_keypad.sv
// PS/2 key events to Studio II keypads; OUT-latched key select drives EF3/EF4.
module studio2_keypad
    import studio2_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 500000,
    parameter logic [2:0]  KEYSEL_PORT = 3'd2
) (
    input  logic        clock,
    input  logic        resetq,
    input  logic [10:0] ps2_key,
    input  logic        io_out,
    input  logic [2:0]  io_n,
    input  logic [7:0]  io_dout,
    output logic        ef3,
    output logic        ef4,
    output logic [3:0]  key_sel,
    output logic [9:0]  kp1_keys,
    output logic [9:0]  kp2_keys
);

    logic     toggle_q;
    logic     key_event;
    logic     hit1, hit2;
    key_num_t idx1, idx2;
    logic     unused_dout_hi;

    assign unused_dout_hi = &{1'b0, io_dout[7:4]};
    assign key_event = (ps2_key[10] != toggle_q) && !ps2_key[8];

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx1 = '0;
        idx2 = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (ps2_key[7:0] == KP1_CODES[i]) begin
                hit1 = 1'b1;
                idx1 = key_num_t'(i);
            end
            if (ps2_key[7:0] == KP2_CODES[i]) begin
                hit2 = 1'b1;
                idx2 = key_num_t'(i);
            end
        end
    end

    studio2_key_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_kp1 (
        .clock     (clock),
        .resetq    (resetq),
        .key_make  (key_event && hit1 && ps2_key[9]),
        .key_break (key_event && hit1 && !ps2_key[9]),
        .key       (idx1),
        .keys      (kp1_keys)
    );

    studio2_key_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_kp2 (
        .clock     (clock),
        .resetq    (resetq),
        .key_make  (key_event && hit2 && ps2_key[9]),
        .key_break (key_event && hit2 && !ps2_key[9]),
        .key       (idx2),
        .keys      (kp2_keys)
    );

    // Zero-extended so key_sel 10..15 reads as "no key"
    logic [15:0] kp1_ext, kp2_ext;
    assign kp1_ext = {6'b0, kp1_keys};
    assign kp2_ext = {6'b0, kp2_keys};

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            toggle_q <= 1'b0;
            key_sel  <= '0;
            ef3      <= 1'b0;
            ef4      <= 1'b0;
        end else begin
            toggle_q <= ps2_key[10];
            if (io_out && io_n == KEYSEL_PORT)
                key_sel <= io_dout[3:0];
            ef3 <= kp1_ext[key_sel];
            ef4 <= kp2_ext[key_sel];
        end
    end

endmodule
